// File: rtl/tim_apb_arb.sv
// Two-requester round-robin arbiter in front of one APB timer slave.
// Ports: sys_clk/sys_rst; rq0_*/rq1_* requesters; tim_* APB master; arb_busy.
module tim_apb_arb #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rq0_req,
  input  logic        rq0_write,
  input  logic [11:0] rq0_addr,
  input  logic [31:0] rq0_wdata,
  input  logic [3:0]  rq0_strb,
  output logic        rq0_ack,
  output logic [31:0] rq0_rdata,
  output logic        rq0_err,
  input  logic        rq1_req,
  input  logic        rq1_write,
  input  logic [11:0] rq1_addr,
  input  logic [31:0] rq1_wdata,
  input  logic [3:0]  rq1_strb,
  output logic        rq1_ack,
  output logic [31:0] rq1_rdata,
  output logic        rq1_err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [11:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        busy_q, busy_d;

  logic        win;
  logic        fin_err;
  logic [31:0] fin_rdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    ack_d     = 2'b00;
    err_d     = err_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          // rq1 wins if alone, or on a tie when the pointer favours it
          win      = rq1_req && (!rq0_req || ptr_q);
          gnt_d    = win;
          ptr_d    = !win;
          cnt_d    = '0;
          psel_d   = 1'b1;
          pwrite_d = win ? rq1_write : rq0_write;
          paddr_d  = win ? rq1_addr : rq0_addr;
          pwdata_d = pwrite_d ? (win ? rq1_wdata : rq0_wdata) : '0;
          pstrb_d  = pwrite_d ? (win ? rq1_strb : rq0_strb) : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (tim_pready || cnt_q == TO_LAST) begin
          // a ready in the final counted cycle still completes normally
          fin_rdata = (tim_pready && !pwrite_q) ? tim_prdata : '0;
          fin_err   = tim_pready ? tim_pslverr : 1'b1;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          if (gnt_q) begin
            rdata1_d = fin_rdata;
            err_d[1] = fin_err;
          end else begin
            rdata0_d = fin_rdata;
            err_d[0] = fin_err;
          end
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          pstrb_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
    end
  end

  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;
  assign rq0_ack     = ack_q[0];
  assign rq1_ack     = ack_q[1];
  assign rq0_err     = err_q[0];
  assign rq1_err     = err_q[1];
  assign rq0_rdata   = rdata0_q;
  assign rq1_rdata   = rdata1_q;
  assign arb_busy    = busy_q;

endmodule

// File: tb/tb_tim_apb_arb.sv
// Directed bench for tim_apb_arb: table of transfers plus
// hand sequences for timeout, req held through DONE and mid-transfer reset.
module tb_tim_apb_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rq0_req, rq0_write, rq0_ack, rq0_err;
  logic [11:0] rq0_addr;
  logic [31:0] rq0_wdata, rq0_rdata;
  logic [3:0]  rq0_strb;
  logic        rq1_req, rq1_write, rq1_ack, rq1_err;
  logic [11:0] rq1_addr;
  logic [31:0] rq1_wdata, rq1_rdata;
  logic [3:0]  rq1_strb;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata, tim_prdata;
  logic [3:0]  tim_pstrb;
  logic        tim_pready, tim_pslverr, arb_busy;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  logic [31:0] m_rdata [2];
  logic        m_err   [2];

  always #5 sys_clk = ~sys_clk;

  tim_apb_arb #(.TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_strb(rq0_strb), .rq0_ack(rq0_ack),
    .rq0_rdata(rq0_rdata), .rq0_err(rq0_err),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_strb(rq1_strb), .rq1_ack(rq1_ack),
    .rq1_rdata(rq1_rdata), .rq1_err(rq1_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready),
    .tim_pslverr(tim_pslverr), .arb_busy(arb_busy)
  );

  typedef struct {
    logic        r0;
    logic        r1;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic        gnt;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL case%0d %s got=%h exp=%h", cur, nm, act, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " psel"}, 32'(tim_psel), 0);
    chk({tag, " penable"}, 32'(tim_penable), 0);
    chk({tag, " pwrite"}, 32'(tim_pwrite), 0);
    chk({tag, " paddr"}, 32'(tim_paddr), 0);
    chk({tag, " pwdata"}, tim_pwdata, 0);
    chk({tag, " pstrb"}, 32'(tim_pstrb), 0);
  endtask

  task automatic chk_held();
    chk("rdata0 held", rq0_rdata, m_rdata[0]);
    chk("rdata1 held", rq1_rdata, m_rdata[1]);
    chk("err0 held", 32'(rq0_err), 32'(m_err[0]));
    chk("err1 held", 32'(rq1_err), 32'(m_err[1]));
  endtask

  task automatic chk_bus(input string tag, input logic en, input vec_t v);
    chk({tag, " psel"}, 32'(tim_psel), 1);
    chk({tag, " penable"}, 32'(tim_penable), 32'(en));
    chk({tag, " pwrite"}, 32'(tim_pwrite), 32'(v.wr));
    chk({tag, " paddr"}, 32'(tim_paddr), 32'(v.addr));
    chk({tag, " pwdata"}, tim_pwdata, v.wr ? v.wdata : 32'h0);
    chk({tag, " pstrb"}, 32'(tim_pstrb), v.wr ? 32'(v.strb) : 32'h0);
    chk({tag, " busy"}, 32'(arb_busy), 1);
    chk({tag, " ack0"}, 32'(rq0_ack), 0);
    chk({tag, " ack1"}, 32'(rq1_ack), 0);
  endtask

  // Winner's fields come from the vector; the other requester sees
  // inverted values so a wrong mux select shows up on the bus.
  task automatic drive_reqs(input vec_t v);
    rq0_req = v.r0;
    rq1_req = v.r1;
    rq0_write = v.gnt ? ~v.wr : v.wr;
    rq1_write = v.gnt ? v.wr : ~v.wr;
    rq0_addr  = v.gnt ? ~v.addr : v.addr;
    rq1_addr  = v.gnt ? v.addr : ~v.addr;
    rq0_wdata = v.gnt ? ~v.wdata : v.wdata;
    rq1_wdata = v.gnt ? v.wdata : ~v.wdata;
    rq0_strb  = v.gnt ? ~v.strb : v.strb;
    rq1_strb  = v.gnt ? v.strb : ~v.strb;
  endtask

  // Called with the DUT idle; drives requests in cycle T and follows the
  // transfer to the IDLE cycle after its ack.
  task automatic run_xfer(input vec_t v);
    logic [31:0] exp_rd;
    drive_reqs(v);
    tim_pready = 1'b0;
    step();
    chk_bus("setup", 1'b0, v);
    for (int k = 0; k <= v.waits; k++) begin
      step();
      chk_bus("access", 1'b1, v);
      tim_pready  = (k == v.waits);
      tim_pslverr = (k == v.waits) ? v.slverr : 1'b1;
      tim_prdata  = (k == v.waits) ? v.prdata : 32'h0BAD_0BAD;
    end
    step();
    exp_rd = v.wr ? 32'h0 : v.prdata;
    m_rdata[v.gnt] = exp_rd;
    m_err[v.gnt]   = v.slverr;
    chk("done ack0", 32'(rq0_ack), 32'(!v.gnt));
    chk("done ack1", 32'(rq1_ack), 32'(v.gnt));
    chk_held();
    chk_idle_bus("done");
    chk("done busy", 32'(arb_busy), 1);
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;
    step();
    chk("idle ack0", 32'(rq0_ack), 0);
    chk("idle ack1", 32'(rq1_ack), 0);
    chk("idle busy", 32'(arb_busy), 0);
    chk_idle_bus("idle");
    chk_held();
  endtask

  initial begin
    vec_t tv;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 0, 1'b0,
                32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 12'h004, 32'h0, 4'hF, 3, 1'b0,
                32'hDEAD_BEEF, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 12'h020, 32'h55AA_55AA, 4'hF, 0, 1'b1,
                32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 12'h008, 32'h0, 4'hF, 1, 1'b0,
                32'hCAFE_0001, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h5, 2, 1'b0,
                32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 12'h0FF, 32'h8765_4321, 4'h3, 0, 1'b0,
                32'h1234_5678, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 12'h100, 32'h1111_2222, 4'hC, 0, 1'b0,
                32'h0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 12'h200, 32'h0, 4'hF, 0, 1'b1,
                32'h7777_8888, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 12'h3FC, 32'hFFFF_FFFF, 4'h1, 1, 1'b0,
                32'h0, 1'b0};

    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_err[0]   = 1'b0;
    m_err[1]   = 1'b0;
    sys_rst = 1'b1;
    rq0_req = 0; rq0_write = 0; rq0_addr = 0; rq0_wdata = 0; rq0_strb = 0;
    rq1_req = 0; rq1_write = 0; rq1_addr = 0; rq1_wdata = 0; rq1_strb = 0;
    tim_prdata = 0; tim_pready = 0; tim_pslverr = 0;
    step();
    step();
    chk_idle_bus("reset");
    chk("reset ack0", 32'(rq0_ack), 0);
    chk("reset ack1", 32'(rq1_ack), 0);
    chk("reset busy", 32'(arb_busy), 0);
    chk_held();
    sys_rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      cur = i;
      run_xfer(vecs[i]);
    end

    // timeout: rq1 read, slave never ready; req stays high through DONE
    cur = 100;
    tv = '{1'b0, 1'b1, 1'b0, 12'h030, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b1};
    drive_reqs(tv);
    tim_pready = 1'b0;
    tim_prdata = 32'h1357_9BDF;
    step();
    chk_bus("to setup", 1'b0, tv);
    for (int k = 0; k < 16; k++) begin
      step();
      chk_bus("to access", 1'b1, tv);
    end
    step();
    m_rdata[1] = 32'h0;
    m_err[1]   = 1'b1;
    chk("to ack1", 32'(rq1_ack), 1);
    chk("to ack0", 32'(rq0_ack), 0);
    chk_held();
    chk_idle_bus("to done");
    tim_pready = 1'b1;
    tim_prdata = 32'hFFFF_FFFF;
    step();
    chk("late ready ack1", 32'(rq1_ack), 0);
    chk("held req idle psel", 32'(tim_psel), 0);
    chk("held req idle busy", 32'(arb_busy), 0);
    chk_held();
    tim_pready = 1'b0;

    // the still-held request starts only now; reset it in ACCESS #2
    cur = 101;
    step();
    chk_bus("rs setup", 1'b0, tv);
    step();
    chk_bus("rs access1", 1'b1, tv);
    step();
    chk_bus("rs access2", 1'b1, tv);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    rq1_req = 1'b0;
    m_rdata[1] = 32'h0;
    m_err[1]   = 1'b0;
    chk_idle_bus("rs after");
    chk("rs busy", 32'(arb_busy), 0);
    chk("rs ack1", 32'(rq1_ack), 0);
    chk("rs ack0", 32'(rq0_ack), 0);
    chk_held();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rs quiet ack1", 32'(rq1_ack), 0);
      chk("rs quiet psel", 32'(tim_psel), 0);
    end

    cur = 102;
    tv = '{1'b0, 1'b1, 1'b0, 12'h044, 32'h0, 4'hF, 0, 1'b0,
           32'h0BAD_F00D, 1'b1};
    run_xfer(tv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
